arp_ctrl: RTL and testbench

ARP/transmit controller placed between the ARP receive parser, the ARP transmit frame builder and the UDP transmit path, all of which share one MAC TX channel. It issues ARP requests at start-up and retries them until the PC answers, and caches the PC's MAC/IP from replies. It queues an ARP reply whenever the PC sends a request. It arbitrates the TX channel: pending ARP traffic is served before UDP, and UDP is granted only once the cache holds a valid PC address.

---
 rtl/arp_ctrl.sv | 155 +++++++++++++++
 tb/tb_arp_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/arp_ctrl.sv
// ARP/transmit controller: issues and retries ARP requests, caches the PC address from replies,
// queues replies to PC requests and arbitrates the shared MAC TX channel between ARP and UDP.
module arp_ctrl #(
    parameter logic [31:0] pc_ip_default = 32'hc0a8_0002,
    parameter int unsigned retry_cycles  = 125_000_000,
    parameter int unsigned max_retry     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arp_rx_done,
    input  logic        arp_rx_op,
    input  logic [47:0] pc_mac_in,
    input  logic [31:0] pc_ip_in,
    input  logic        arp_tx_busy,
    input  logic        arp_tx_done,
    output logic        arp_tx_start,
    output logic        arp_tx_type,
    output logic [47:0] dst_mac,
    output logic [31:0] dst_ip,
    input  logic        udp_tx_req,
    input  logic        udp_tx_done,
    output logic        udp_tx_grant,
    output logic        cache_vld,
    output logic        arp_fail
);

    typedef enum logic [1:0] {StArb, StArpSend, StArpWait, StUdpXfer} state_e;

    localparam logic [31:0] TcntLast = 32'(retry_cycles - 1);
    localparam logic [7:0]  RcntMax  = 8'(max_retry);

    state_e      state_q, state_d;
    logic        req_pend_q, req_pend_d;
    logic        reply_pend_q, reply_pend_d;
    logic [7:0]  rcnt_q, rcnt_d;
    logic [31:0] tcnt_q, tcnt_d;
    logic        cache_vld_q, cache_vld_d;
    logic        arp_fail_q, arp_fail_d;
    logic        start_q, start_d;
    logic        type_q, type_d;
    logic [47:0] mac_q, mac_d;
    logic [31:0] ip_q, ip_d;

    logic rx_reply, rx_req, timer_run;

    assign rx_reply  = arp_rx_done && !arp_rx_op;
    assign rx_req    = arp_rx_done && arp_rx_op;
    assign timer_run = !cache_vld_q && !arp_fail_q && !req_pend_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StArb;
            req_pend_q   <= 1'b1;
            reply_pend_q <= 1'b0;
            rcnt_q       <= 8'd0;
            tcnt_q       <= 32'd0;
            cache_vld_q  <= 1'b0;
            arp_fail_q   <= 1'b0;
            start_q      <= 1'b0;
            type_q       <= 1'b1;
            mac_q        <= 48'd0;
            ip_q         <= 32'd0;
        end else begin
            state_q      <= state_d;
            req_pend_q   <= req_pend_d;
            reply_pend_q <= reply_pend_d;
            rcnt_q       <= rcnt_d;
            tcnt_q       <= tcnt_d;
            cache_vld_q  <= cache_vld_d;
            arp_fail_q   <= arp_fail_d;
            start_q      <= start_d;
            type_q       <= type_d;
            mac_q        <= mac_d;
            ip_q         <= ip_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_pend_d   = req_pend_q;
        reply_pend_d = reply_pend_q;
        rcnt_d       = rcnt_q;
        tcnt_d       = tcnt_q;
        cache_vld_d  = cache_vld_q;
        arp_fail_d   = arp_fail_q;
        start_d      = 1'b0;
        type_d       = type_q;
        mac_d        = mac_q;
        ip_d         = ip_q;

        case (state_q)
            StArb: begin
                if (reply_pend_q) begin
                    state_d = StArpSend;
                    type_d  = 1'b0;
                end else if (req_pend_q) begin
                    state_d = StArpSend;
                    type_d  = 1'b1;
                end else if (udp_tx_req && cache_vld_q) begin
                    state_d = StUdpXfer;
                end
            end
            StArpSend: begin
                if (!arp_tx_busy) begin
                    start_d = 1'b1;
                    state_d = StArpWait;
                    if (type_q) begin
                        req_pend_d = 1'b0;
                        rcnt_d     = rcnt_q + 8'd1;
                    end else begin
                        reply_pend_d = 1'b0;
                    end
                end
            end
            StArpWait: begin
                if (arp_tx_done) state_d = StArb;
            end
            StUdpXfer: begin
                if (udp_tx_done) state_d = StArb;
            end
            default: state_d = StArb;
        endcase

        if (timer_run) begin
            if (tcnt_q == TcntLast) begin
                tcnt_d = 32'd0;
                if (rcnt_q == RcntMax) arp_fail_d = 1'b1;
                else                   req_pend_d = 1'b1;
            end else begin
                tcnt_d = tcnt_q + 32'd1;
            end
        end

        // Applied after the service clear so a new request in the same cycle is not lost.
        if (rx_req) reply_pend_d = 1'b1;

        if (rx_reply) begin
            mac_d       = pc_mac_in;
            ip_d        = pc_ip_in;
            cache_vld_d = 1'b1;
            arp_fail_d  = 1'b0;
            req_pend_d  = 1'b0;
            rcnt_d      = 8'd0;
        end
    end

    assign arp_tx_start = start_q;
    assign arp_tx_type  = type_q;
    assign dst_mac      = cache_vld_q ? mac_q : 48'hffff_ffff_ffff;
    assign dst_ip       = cache_vld_q ? ip_q : pc_ip_default;
    assign udp_tx_grant = (state_q == StUdpXfer);
    assign cache_vld    = cache_vld_q;
    assign arp_fail     = arp_fail_q;

endmodule

// File: tb/tb_arp_ctrl.sv
// Directed bench for arp_ctrl: retries, failure, cache fill, reply coalescing, arbitration, reset.
module tb_arp_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arp_rx_done, arp_rx_op;
    logic [47:0] pc_mac_in;
    logic [31:0] pc_ip_in;
    logic        arp_tx_busy, arp_tx_done;
    logic        arp_tx_start, arp_tx_type;
    logic [47:0] dst_mac;
    logic [31:0] dst_ip;
    logic        udp_tx_req, udp_tx_done, udp_tx_grant;
    logic        cache_vld, arp_fail;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int c0, n, gap;

    arp_ctrl #(
        .pc_ip_default(32'hc0a8_0002),
        .retry_cycles (100),
        .max_retry    (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .arp_rx_done (arp_rx_done),
        .arp_rx_op   (arp_rx_op),
        .pc_mac_in   (pc_mac_in),
        .pc_ip_in    (pc_ip_in),
        .arp_tx_busy (arp_tx_busy),
        .arp_tx_done (arp_tx_done),
        .arp_tx_start(arp_tx_start),
        .arp_tx_type (arp_tx_type),
        .dst_mac     (dst_mac),
        .dst_ip      (dst_ip),
        .udp_tx_req  (udp_tx_req),
        .udp_tx_done (udp_tx_done),
        .udp_tx_grant(udp_tx_grant),
        .cache_vld   (cache_vld),
        .arp_fail    (arp_fail)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // n = cycles until a start pulse is seen, or -1 if none within max_cyc.
    task automatic wait_start(input int max_cyc, output int n_out);
        n_out = -1;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (arp_tx_start === 1'b1) begin
                n_out = i + 1;
                break;
            end
        end
    endtask

    task automatic pulse_arp_done;
        arp_tx_done = 1'b1;
        tick();
        arp_tx_done = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        arp_rx_done = 1'b0; arp_rx_op = 1'b0;
        pc_mac_in = 48'd0; pc_ip_in = 32'd0;
        arp_tx_busy = 1'b0; arp_tx_done = 1'b0;
        udp_tx_req = 1'b0; udp_tx_done = 1'b0;
        repeat (3) tick();

        check("rst_start", arp_tx_start, 0);
        check("rst_type", arp_tx_type, 1);
        check("rst_grant", udp_tx_grant, 0);
        check("rst_cache_vld", cache_vld, 0);
        check("rst_fail", arp_fail, 0);
        check("rst_dst_mac", dst_mac, 48'hffff_ffff_ffff);
        check("rst_dst_ip", dst_ip, 32'hc0a8_0002);

        // First request: start two cycles after reset release.
        rst_n = 1'b1;
        tick();
        check("start_cyc1", arp_tx_start, 0);
        tick();
        check("start_cyc2", arp_tx_start, 1);
        check("start1_type", arp_tx_type, 1);
        check("start1_dst_mac", dst_mac, 48'hffff_ffff_ffff);
        c0 = cyc;
        tick();
        check("start_one_cycle", arp_tx_start, 0);
        pulse_arp_done();

        // Retry after ~retry_cycles.
        wait_start(150, n);
        check("retry2_seen", (n != -1), 1);
        gap = cyc - c0;
        check("retry2_gap", ((gap >= 100) && (gap <= 104)), 1);
        check("retry2_type", arp_tx_type, 1);
        c0 = cyc;
        pulse_arp_done();

        wait_start(150, n);
        check("retry3_seen", (n != -1), 1);
        gap = cyc - c0;
        check("retry3_gap", ((gap >= 100) && (gap <= 104)), 1);
        pulse_arp_done();

        // Third attempt unanswered: fail, no more starts; UDP not granted without cache.
        udp_tx_req = 1'b1;
        wait_start(250, n);
        check("no_4th_start", n, -1);
        check("fail_set", arp_fail, 1);
        check("no_grant_invalid", udp_tx_grant, 0);

        // Reply fills cache.
        pc_mac_in = 48'h1c83_41c5_caa6;
        pc_ip_in  = 32'hc0a8_0002;
        arp_rx_op = 1'b0;
        arp_rx_done = 1'b1;
        tick();
        arp_rx_done = 1'b0;
        check("cache_vld_set", cache_vld, 1);
        check("cache_mac", dst_mac, 48'h1c83_41c5_caa6);
        check("cache_ip", dst_ip, 32'hc0a8_0002);
        check("fail_cleared", arp_fail, 0);
        check("grant_not_yet", udp_tx_grant, 0);
        tick();
        check("grant_rise", udp_tx_grant, 1);

        // Two PC requests during the UDP frame coalesce into one reply.
        arp_rx_op = 1'b1;
        arp_rx_done = 1'b1;
        tick();
        arp_rx_done = 1'b0;
        tick();
        arp_rx_done = 1'b1;
        tick();
        arp_rx_done = 1'b0;
        check("udp_not_preempted", udp_tx_grant, 1);
        check("no_start_in_udp", arp_tx_start, 0);

        udp_tx_done = 1'b1;
        tick();
        udp_tx_done = 1'b0;
        check("grant_fall", udp_tx_grant, 0);
        tick();
        check("reply_arb_start", arp_tx_start, 0);
        check("reply_type_sel", arp_tx_type, 0);
        tick();
        check("reply_start", arp_tx_start, 1);
        check("reply_type", arp_tx_type, 0);
        pulse_arp_done();
        check("reply_start_low", arp_tx_start, 0);
        tick();
        check("grant_after_reply", udp_tx_grant, 1);

        udp_tx_req = 1'b0;
        udp_tx_done = 1'b1;
        tick();
        udp_tx_done = 1'b0;
        check("grant_fall2", udp_tx_grant, 0);
        wait_start(150, n);
        check("no_dup_or_retry", n, -1);

        // Reset during UDP transfer.
        udp_tx_req = 1'b1;
        tick();
        check("grant_again", udp_tx_grant, 1);
        rst_n = 1'b0;
        tick();
        check("rst_mid_grant", udp_tx_grant, 0);
        check("rst_mid_start", arp_tx_start, 0);
        check("rst_mid_type", arp_tx_type, 1);
        check("rst_mid_cache", cache_vld, 0);
        check("rst_mid_mac", dst_mac, 48'hffff_ffff_ffff);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
